alu_req_arbiter: RTL and testbench

- Round-robin command arbiter and sequencer sharing one tinyalu instance between NUM_REQ requesters.
- Each requester submits (op, A, B) over a valid/ready port.
- The block drives tinyalu start/op/A/B, holds start until done, and returns the 16-bit result tagged with the requester id.
- Sits between stimulus BFMs or higher-level masters and the tinyalu datapath.

---
 rtl/alu_req_arbiter_pkg.sv | 24 ++
 rtl/alu_req_arbiter_if.sv | 45 ++++
 rtl/alu_req_arbiter_rr_arbiter.sv | 40 ++++
 rtl/alu_req_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_req_arbiter_pkg.sv
// Shared types and widths for the tinyalu request arbiter.
// Op codes 5-7 have no enum member; they travel as raw OP_W-bit values.
package alu_arb_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 8;
    localparam int RES_W  = 16;

    typedef enum logic [OP_W-1:0] {
        NOP = 3'd0,
        ADD = 3'd1,
        AND = 3'd2,
        XOR = 3'd3,
        MUL = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Requester, tinyalu and response signals of the arbiter in one bundle.
// Port suffixes are relative to the arbiter: slave = arbiter, master = environment.
interface alu_req_arbiter_if
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3
);
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [OP_W*NUM_REQ-1:0]   req_op_i;
    logic [DATA_W*NUM_REQ-1:0] req_a_i;
    logic [DATA_W*NUM_REQ-1:0] req_b_i;

    logic                      alu_start_o;
    logic [OP_W-1:0]           alu_op_o;
    logic [DATA_W-1:0]         alu_a_o;
    logic [DATA_W-1:0]         alu_b_o;
    logic                      alu_done_i;
    logic [RES_W-1:0]          alu_result_i;

    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [ID_W-1:0]           rsp_id_o;
    logic [RES_W-1:0]          rsp_result_o;
    logic                      rsp_err_o;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i,
        output req_ready_o,
        output alu_start_o, alu_op_o, alu_a_o, alu_b_o,
        input  alu_done_i, alu_result_i,
        output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_err_o,
        input  rsp_ready_i
    );

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i,
        input  req_ready_o,
        input  alu_start_o, alu_op_o, alu_a_o, alu_b_o,
        output alu_done_i, alu_result_i,
        input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_err_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/alu_req_arbiter_rr_arbiter.sv
// Round-robin picker: combinational winner searching from pointer+1, pointer
// moves to the winner when en_i is set. Pointer resets to N-1 so index 0 goes first.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic             any_o
);
    logic [PTR_W-1:0] ptr_q;

    always_comb begin
        int idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!any_o && req_i[PTR_W'(idx)]) begin
                any_o               = 1'b1;
                gnt_idx_o           = PTR_W'(idx);
                gnt_o[PTR_W'(idx)]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= PTR_W'(N - 1);
        end else if (en_i) begin
            ptr_q <= gnt_idx_o;
        end
    end
endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one tinyalu between NUM_REQ requesters: RR grant, hold start until done
// or timeout, return tagged result. Optional counters under ALU_ARB_STATS_EN.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ID_W           = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    alu_req_arbiter_if.slave  bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]       stat_cmd_cnt_o,
    output logic [31:0]       stat_busy_cnt_o
`endif
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e        state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;

    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               any_req;
    logic               grant_en;
    logic               tmo_hit;
    logic [OP_W-1:0]    win_op;
    logic [DATA_W-1:0]  win_a, win_b;

    assign grant_en = (state_q == IDLE) && any_req;
    assign tmo_hit  = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign win_op   = bus.req_op_i[int'(gnt_idx)*OP_W +: OP_W];
    assign win_a    = bus.req_a_i[int'(gnt_idx)*DATA_W +: DATA_W];
    assign win_b    = bus.req_b_i[int'(gnt_idx)*DATA_W +: DATA_W];

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .clk_i     (clk_i),
        .rst_i     (reset_i),
        .req_i     (bus.req_valid_i),
        .en_i      (grant_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (any_req)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = (win_op == NOP) ? RESP : ISSUE;
            ISSUE:   if (bus.alu_done_i || tmo_hit) state_d = RESP;
            RESP:    if (bus.rsp_ready_i) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command/response holding registers; done takes priority over a same-cycle timeout.
    always_comb begin
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        id_d  = id_q;
        res_d = res_q;
        err_d = err_q;
        tmo_d = tmo_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    op_d  = win_op;
                    a_d   = win_a;
                    b_d   = win_b;
                    id_d  = ID_W'(gnt_idx);
                    res_d = '0;
                    err_d = 1'b0;
                    tmo_d = '0;
                end
            end
            ISSUE: begin
                if (bus.alu_done_i) begin
                    res_d = bus.alu_result_i;
                    err_d = 1'b0;
                end else if (tmo_hit) begin
                    res_d = '0;
                    err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            id_q  <= '0;
            res_q <= '0;
            err_q <= 1'b0;
            tmo_q <= '0;
        end else begin
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            id_q  <= id_d;
            res_q <= res_d;
            err_q <= err_d;
            tmo_q <= tmo_d;
        end
    end

    // The ready pulse is combinational from valid, so it is masked while reset is held.
    always_comb begin
        bus.req_ready_o  = (state_q == IDLE && !reset_i) ? gnt : '0;
        bus.alu_start_o  = (state_q == ISSUE);
        bus.alu_op_o     = (state_q == ISSUE) ? op_q : '0;
        bus.alu_a_o      = (state_q == ISSUE) ? a_q  : '0;
        bus.alu_b_o      = (state_q == ISSUE) ? b_q  : '0;
        bus.rsp_valid_o  = (state_q == RESP);
        bus.rsp_id_o     = (state_q == RESP) ? id_q  : '0;
        bus.rsp_result_o = (state_q == RESP) ? res_q : '0;
        bus.rsp_err_o    = (state_q == RESP) ? err_q : 1'b0;
    end

`ifdef ALU_ARB_STATS_EN
    logic [31:0] cmd_cnt_q, busy_cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cmd_cnt_q  <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (state_q == RESP && bus.rsp_ready_i) cmd_cnt_q <= cmd_cnt_q + 32'd1;
            if (state_q != IDLE) busy_cnt_q <= busy_cnt_q + 32'd1;
        end
    end

    assign stat_cmd_cnt_o  = cmd_cnt_q;
    assign stat_busy_cnt_o = busy_cnt_q;
`endif
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural tinyalu of configurable
// latency; inputs change and outputs are sampled 1-2 ns after the rising edge.
module tb_alu_req_arbiter;
    import alu_arb_pkg::*;

    localparam int NR  = 4;
    localparam int TO  = 16;
    localparam int IDW = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_req_arbiter_if #(.NUM_REQ(NR), .ID_W(IDW)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [31:0] stat_cmd, stat_busy;
`endif

    alu_req_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO),
        .ID_W           (IDW)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_cmd_cnt_o  (stat_cmd),
        .stat_busy_cnt_o (stat_busy)
`endif
    );

    // Behavioural tinyalu: done after alu_lat cycles of start, or never when stuck.
    int   alu_lat;
    logic alu_stuck;
    int   lat_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst || !bus.alu_start_o) lat_cnt <= 0;
        else                         lat_cnt <= lat_cnt + 1;
    end

    assign bus.alu_done_i = bus.alu_start_o && !alu_stuck && (lat_cnt == alu_lat - 1);

    always_comb begin
        case (bus.alu_op_o)
            3'd1:    bus.alu_result_i = {8'h00, bus.alu_a_o} + {8'h00, bus.alu_b_o};
            3'd2:    bus.alu_result_i = {8'h00, bus.alu_a_o & bus.alu_b_o};
            3'd3:    bus.alu_result_i = {8'h00, bus.alu_a_o ^ bus.alu_b_o};
            3'd4:    bus.alu_result_i = 16'(bus.alu_a_o) * 16'(bus.alu_b_o);
            default: bus.alu_result_i = 16'h0000;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input int k, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp_res,
                          input logic exp_err, input int exp_starts, input string tag);
        int         starts;
        bit         stable;
        logic [3:0] m;
        m = '0;
        m[k] = 1'b1;
        bus.req_valid_i[k]       = 1'b1;
        bus.req_op_i[k*3 +: 3]   = op;
        bus.req_a_i[k*8 +: 8]    = a;
        bus.req_b_i[k*8 +: 8]    = b;
        #1;
        chk({tag, "_ready"}, 64'(bus.req_ready_o), 64'(m));
        next();
        bus.req_valid_i[k] = 1'b0;
        starts = 0;
        stable = 1'b1;
        for (int c = 0; c < 40 && !bus.rsp_valid_o; c++) begin
            if (bus.alu_start_o) begin
                starts++;
                if ({bus.alu_op_o, bus.alu_a_o, bus.alu_b_o} !== {op, a, b}) stable = 1'b0;
            end
            if (bus.req_ready_o !== 4'b0000) stable = 1'b0;
            next();
        end
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'd1);
        chk({tag, "_rsp_id"},    64'(bus.rsp_id_o),    64'(k));
        chk({tag, "_result"},    64'(bus.rsp_result_o), 64'(exp_res));
        chk({tag, "_err"},       64'(bus.rsp_err_o),   64'(exp_err));
        chk({tag, "_starts"},    64'(starts),          64'(exp_starts));
        chk({tag, "_issue_stable"}, 64'(stable),       64'd1);
        chk({tag, "_start_in_resp"}, 64'(bus.alu_start_o), 64'd0);
        next();
        chk({tag, "_gap"}, 64'({bus.rsp_valid_o, bus.alu_start_o, bus.req_ready_o}), 64'd0);
        next();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   stall_ok;
        int   w;
        logic [3:0]  m;
        logic [15:0] xor_exp [4];
        xor_exp[0] = 16'h0033;
        xor_exp[1] = 16'h0081;
        xor_exp[2] = 16'h00F0;
        xor_exp[3] = 16'h00FF;

        rst                 = 1'b1;
        bus.req_valid_i     = 4'b0001;
        bus.req_op_i        = {4{3'd1}};
        bus.req_a_i         = '0;
        bus.req_b_i         = '0;
        bus.rsp_ready_i     = 1'b1;
        alu_lat             = 1;
        alu_stuck           = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 64'({bus.req_ready_o, bus.alu_start_o, bus.rsp_valid_o, bus.rsp_err_o}), 64'd0);
        chk("reset_data", 64'({bus.alu_op_o, bus.alu_a_o, bus.alu_b_o, bus.rsp_id_o, bus.rsp_result_o}), 64'd0);
        bus.req_valid_i = '0;
        rst = 1'b0;
        next();

        do_cmd(0, 3'd1, 8'h05, 8'h03, 16'h0008, 1'b0, 1, "add0");
        alu_lat = 3;
        do_cmd(2, 3'd4, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 3, "mul2");
        alu_lat = 1;
        do_cmd(1, 3'd0, 8'h12, 8'h34, 16'h0000, 1'b0, 0, "nop1");
        alu_stuck = 1'b1;
        do_cmd(3, 3'd1, 8'h01, 8'h01, 16'h0000, 1'b1, TO, "tmo3");
        alu_stuck = 1'b0;

        // Round robin with all four requesters continuously valid.
        rst = 1'b1;
        next();
        rst = 1'b0;
        bus.req_op_i    = {4{3'd3}};
        bus.req_a_i     = {8'h5A, 8'hFF, 8'h80, 8'h11};
        bus.req_b_i     = {8'hA5, 8'h0F, 8'h01, 8'h22};
        bus.req_valid_i = 4'b1111;
        #1;
        for (int g = 0; g < 8; g++) begin
            w = 0;
            while (bus.req_ready_o == 4'b0000 && w < 10) begin
                next();
                w++;
            end
            m = '0;
            m[g % 4] = 1'b1;
            chk("rr_grant", 64'(bus.req_ready_o), 64'(m));
            next();
            w = 0;
            while (!bus.rsp_valid_o && w < 10) begin
                next();
                w++;
            end
            chk("rr_rsp_id", 64'(bus.rsp_id_o), 64'(g % 4));
            chk("rr_result", 64'(bus.rsp_result_o), 64'(xor_exp[g % 4]));
            next();
        end
        bus.req_valid_i = '0;
        next();

        // Response back-pressure: state and outputs frozen, no grant to a waiting requester.
        bus.rsp_ready_i       = 1'b0;
        bus.req_op_i[2:0]     = 3'd1;
        bus.req_a_i[7:0]      = 8'h01;
        bus.req_b_i[7:0]      = 8'h02;
        bus.req_valid_i[0]    = 1'b1;
        #1;
        next();
        bus.req_valid_i[0] = 1'b0;
        w = 0;
        while (!bus.rsp_valid_o && w < 5) begin
            next();
            w++;
        end
        bus.req_op_i[5:3]  = 3'd1;
        bus.req_valid_i[1] = 1'b1;
        stall_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!(bus.rsp_valid_o === 1'b1 && bus.rsp_id_o === 3'd0 &&
                  bus.rsp_result_o === 16'h0003 && bus.rsp_err_o === 1'b0 &&
                  bus.req_ready_o === 4'b0000 && bus.alu_start_o === 1'b0)) stall_ok = 1'b0;
            next();
        end
        chk("stall_stable", 64'(stall_ok), 64'd1);
        chk("stall_result", 64'(bus.rsp_result_o), 64'h0003);
        bus.rsp_ready_i = 1'b1;
        next();
        bus.req_valid_i[1] = 1'b0;
        chk("stall_released", 64'(bus.rsp_valid_o), 64'd0);
        next();

        // Reset in the middle of a multi-cycle ISSUE.
        alu_lat               = 5;
        bus.req_op_i[8:6]     = 3'd4;
        bus.req_a_i[23:16]    = 8'h03;
        bus.req_b_i[23:16]    = 8'h04;
        bus.req_valid_i[2]    = 1'b1;
        #1;
        next();
        bus.req_valid_i[2] = 1'b0;
        next();
        chk("mid_issue_start", 64'(bus.alu_start_o), 64'd1);
        bus.req_valid_i[3] = 1'b1;
        rst = 1'b1;
        #1;
        chk("async_rst_ctrl", 64'({bus.req_ready_o, bus.alu_start_o, bus.rsp_valid_o, bus.rsp_err_o}), 64'd0);
        chk("async_rst_data", 64'({bus.alu_op_o, bus.alu_a_o, bus.alu_b_o, bus.rsp_id_o, bus.rsp_result_o}), 64'd0);
        next();
        rst = 1'b0;
        bus.req_op_i    = {4{3'd1}};
        bus.req_valid_i = 4'b1001;
        #1;
        chk("ptr_after_rst", 64'(bus.req_ready_o), 64'b0001);
        bus.req_valid_i = 4'b0000;
        #1;
        chk("withdraw_ready", 64'(bus.req_ready_o), 64'd0);
        next();
        chk("withdraw_no_issue", 64'({bus.alu_start_o, bus.rsp_valid_o}), 64'd0);
        alu_lat = 1;
        do_cmd(1, 3'd1, 8'h02, 8'h02, 16'h0004, 1'b0, 1, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
